biriscv_v_alu_seq: RTL and testbench
====================================

# biriscv_v_alu_seq

Issue-side sequencer for the vector ALU. It accepts one vector arithmetic instruction at a time along with its vl/SEW/LMUL context, then walks the register group one VLEN-wide pass per register. For each pass it reads the source and mask registers, drives the combinational vector ALU, and writes the result back with per-byte enables covering body, tail and masked elements. It sits between the vector issue stage and the vector register file (VRF), wrapping the vector ALU.

## Interface
- VLEN, 128, vector register width in bits
- ELEN, 32, maximum element width in bits
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i / req_ready_o  in/out  1  instruction handshake
- req_opcode_i  in  32  instruction word; bit 25 = vm
- req_vd_i, req_vs1_i, req_vs2_i  in  5  base register indices
- req_rs1_operand_i  in  32  scalar operand for .vx/.vi forms
- req_vl_i  in  8  element count, 0..128
- req_vsew_i  in  2  0=8, 1=16, 2=32 bits
- req_vlmul_i  in  2  0=1, 1=2, 2=4, 3=8
- hold_i  in  1  pipeline stall
- vrf_rd_addr_a_o, vrf_rd_addr_b_o  out  5  source addresses; data returns the next cycle
- vrf_rd_data_a_i, vrf_rd_data_b_i, vrf_rd_data_m_i  in  VLEN  read data; the m port is hard-wired to v0
- alu_opcode_o  out  32  opcode to the ALU
- alu_va_o, alu_vb_o, alu_vmask_o  out  VLEN  ALU operands
- alu_result_i  in  VLEN  combinational ALU result
- vrf_wr_en_o  out  1  write strobe
- vrf_wr_addr_o  out  5  write address
- vrf_wr_data_o  out  VLEN  write data
- vrf_wr_be_o  out  VLEN/8  byte enables
- busy_o  out  1  instruction in flight
- done_o  out  1  one-cycle completion pulse
- illegal_o  out  1  one-cycle rejection pulse

## Operation
- FSM states: IDLE, CHECK, READ, EXEC, WRITE.
  - IDLE -> CHECK on accept. Accept requires req_valid_i && req_ready_o. Request fields are latched on accept.
  - CHECK -> IDLE with illegal_o if the request is illegal:
    - vsew==3, or
    - vd/vs1/vs2 not a multiple of LMUL, or
    - vm=0 with vd==0.
  - CHECK -> IDLE with done_o if vl==0.
  - CHECK -> READ otherwise.
- READ: drive vrf_rd_addr_a_o = vs2+k and vrf_rd_addr_b_o = vs1+k, where k is the pass index. Addresses remain stable through EXEC.
- EXEC: drive the ALU.
  - alu_va_o = rd_data_a.
  - alu_vb_o = rd_data_b for .vv forms; for .vx/.vi forms, the scalar is replicated per SEW element.
  - Capture alu_result_i and the byte enables into registers.
- WRITE: assert vrf_wr_en_o with vrf_wr_addr_o = vd+k.
  - Then -> READ for k+1 if k+1 < LMUL and (k+1)·VLEN/SEW < vl.
  - Otherwise -> IDLE with done_o.
- Element e of pass k has global index g = k·(VLEN/SEW)+e. It is active iff g < vl and (vm=1 or v0[g]).
- vrf_wr_be_o covers only active elements. Tail and masked-off bytes are undisturbed.
- alu_vmask_o carries each element's active bit at bit position e·SEW; all other bits are 0.
- vl above VLMAX (= LMUL·VLEN/SEW) is clamped to VLMAX.
- req_ready_o = (state==IDLE).
- busy_o = (state!=IDLE).

## Timing
- Reset values: every output is 0 except req_ready_o, which is 1. The FSM is in IDLE.
- Accept occurs at cycle 0. For a legal request: CHECK in cycle 1, pass k occupies cycles 2+3k .. 4+3k, and done_o pulses in the final WRITE cycle.
- Total latency is 3·passes+1 cycles from accept to done_o.
- illegal_o and vl==0 completion are both signalled in cycle 1.
- hold_i freezes the state, pass index and all registered values.
  - vrf_wr_en_o is gated: (state==WRITE) && !hold_i.
  - done_o and illegal_o are gated by !hold_i. They pulse in the first cycle the FSM leaves the state with hold_i low.
- A new request can be accepted in the cycle after done_o or illegal_o.
- An asynchronous reset mid-instruction returns the FSM to IDLE immediately. The partial VRF writes already made are not undone.

## Configuration
- BIRISCV_VSEQ_MASK_EN defined: vm=0 instructions execute using v0 as described above.
- BIRISCV_VSEQ_MASK_EN undefined: any vm=0 request is illegal (illegal_o in cycle 1). vrf_rd_data_m_i is ignored and alu_vmask_o is all-ones at element LSBs.

## Structure
- Package biriscv_v_pkg holds:
  - the SEW and LMUL encodings,
  - the FSM state enum,
  - default VLEN/ELEN constants,
  - a VLMAX helper function.
- Sub-module biriscv_v_elem_enable is purely combinational. It maps (k, vl, vsew, vm, v0) to vrf_wr_be_o and alu_vmask_o.

## Test plan
- vadd.vv, SEW=32, LMUL=1, vl=4, vm=1 -> one write to vd, be=16'hFFFF, done_o at cycle 4.
- vadd.vv, SEW=8, LMUL=2, vl=20 -> two writes: first be=16'hFFFF, second be=16'h000F; done_o at cycle 7.
- SEW=16, LMUL=4, vl=10 -> early exit after 2 passes with second be=16'h000F; no writes to vd+2 or vd+3.
- vm=0, SEW=32, v0=0x5, vl=4 -> be=16'h0F0F; alu_vmask_o bits 0 and 64 set. With the macro undefined: illegal_o, no write.
- LMUL=2 with vd=3 -> illegal_o in cycle 1, no vrf_wr_en_o; req_ready_o=1 in cycle 2.
- hold_i high for 3 cycles during WRITE -> a single vrf_wr_en_o pulse, data unchanged; done_o delayed by 3 cycles.

Source files
------------

// File: rtl/biriscv_v_alu_seq_pkg.sv
// Shared encodings, FSM states and sizing for the vector ALU sequencer.
package biriscv_v_pkg;

  localparam int unsigned VLEN   = 128;
  localparam int unsigned ELEN   = 32;
  localparam int unsigned VLENB  = VLEN / 8;
  localparam int unsigned BYTE_W = $clog2(VLENB);
  localparam int unsigned BIT_W  = $clog2(VLEN);

  typedef enum logic [1:0] {
    SEW_8    = 2'd0,
    SEW_16   = 2'd1,
    SEW_32   = 2'd2,
    SEW_RSVD = 2'd3
  } vsew_e;

  typedef enum logic [1:0] {
    LMUL_1 = 2'd0,
    LMUL_2 = 2'd1,
    LMUL_4 = 2'd2,
    LMUL_8 = 2'd3
  } vlmul_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4
  } vseq_state_e;

  // Elements per register group: LMUL * VLEN / SEW (0 for the reserved SEW).
  function automatic logic [7:0] vlmax(input logic [1:0] vsew, input logic [1:0] vlmul);
    logic [7:0] n;
    n = 8'(VLENB) >> vsew;
    n = n << vlmul;
    if (vsew == SEW_RSVD) n = '0;
    return n;
  endfunction

endpackage

// File: rtl/biriscv_v_alu_seq_elem_enable.sv
// Per-pass element activity: byte enables for the VRF write and the ALU mask vector.
// BIRISCV_VSEQ_MASK_EN selects whether v0 masking is honoured.
module biriscv_v_elem_enable
  import biriscv_v_pkg::*;
(
  input  logic [2:0]       pass_idx,
  input  logic [7:0]       vl,
  input  logic [1:0]       vsew,
  input  logic             vm,
  input  logic [VLEN-1:0]  v0,
  output logic [VLENB-1:0] byte_en,
  output logic [VLEN-1:0]  vmask
);

  logic [7:0]        pass_base;
  logic [BYTE_W-1:0] low_mask;

  // First global element index of this pass, and the byte-offset bits inside one element.
  assign pass_base = 8'({pass_idx, {BYTE_W{1'b0}}}) >> vsew;
  assign low_mask  = ~({BYTE_W{1'b1}} << vsew);

`ifndef BIRISCV_VSEQ_MASK_EN
  logic unused_mask;
  assign unused_mask = ^{vm, v0};
`endif

  logic [BYTE_W-1:0] elem;
  logic [7:0]        g;
  logic              active;
  logic              is_lsb;

  // Walk every byte lane, derive its element's global index and activity.
  always_comb begin
    byte_en = '0;
    vmask   = '0;
    elem    = '0;
    g       = '0;
    active  = 1'b0;
    is_lsb  = 1'b0;
    for (int unsigned b = 0; b < VLENB; b++) begin
      elem   = BYTE_W'(b) >> vsew;
      g      = pass_base + 8'(elem);
      is_lsb = (BYTE_W'(b) & low_mask) == '0;
`ifdef BIRISCV_VSEQ_MASK_EN
      active = (g < vl) && (vm || v0[g[BIT_W-1:0]]);
      vmask[BIT_W'(b * 8)] = is_lsb && active;
`else
      active = (g < vl);
      vmask[BIT_W'(b * 8)] = is_lsb;
`endif
      byte_en[BYTE_W'(b)] = active;
    end
  end

endmodule

// File: rtl/biriscv_v_alu_seq.sv
// Vector ALU issue sequencer: walks an LMUL register group one VRF row per pass
// (READ -> EXEC -> WRITE). Define BIRISCV_VSEQ_MASK_EN to support vm=0 via v0.
module biriscv_v_alu_seq
  import biriscv_v_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_opcode_i,
  input  logic [4:0]        req_vd_i,
  input  logic [4:0]        req_vs1_i,
  input  logic [4:0]        req_vs2_i,
  input  logic [ELEN-1:0]   req_rs1_operand_i,
  input  logic [7:0]        req_vl_i,
  input  logic [1:0]        req_vsew_i,
  input  logic [1:0]        req_vlmul_i,
  input  logic              hold_i,
  output logic [4:0]        vrf_rd_addr_a_o,
  output logic [4:0]        vrf_rd_addr_b_o,
  input  logic [VLEN-1:0]   vrf_rd_data_a_i,
  input  logic [VLEN-1:0]   vrf_rd_data_b_i,
  input  logic [VLEN-1:0]   vrf_rd_data_m_i,
  output logic [31:0]       alu_opcode_o,
  output logic [VLEN-1:0]   alu_va_o,
  output logic [VLEN-1:0]   alu_vb_o,
  output logic [VLEN-1:0]   alu_vmask_o,
  input  logic [VLEN-1:0]   alu_result_i,
  output logic              vrf_wr_en_o,
  output logic [4:0]        vrf_wr_addr_o,
  output logic [VLEN-1:0]   vrf_wr_data_o,
  output logic [VLENB-1:0]  vrf_wr_be_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o
);

  vseq_state_e      state_q;
  logic [2:0]       pass_q;
  logic [31:0]      opcode_q;
  logic [4:0]       vd_q, vs1_q, vs2_q;
  logic [ELEN-1:0]  scalar_q;
  logic [7:0]       vl_q;
  logic [1:0]       vsew_q, vlmul_q;
  logic [4:0]       rd_addr_a_q, rd_addr_b_q, wr_addr_q;
  logic [VLEN-1:0]  wr_data_q;
  logic [VLENB-1:0] wr_be_q;

  logic [7:0]       req_vlmax;
  logic             vm;
  logic [2:0]       funct3;
  logic             scalar_form;
  logic [4:0]       lmul_low;
  logic [4:0]       lmul_cnt;
  logic             misaligned;
  logic             mask_illegal;
  logic             illegal;
  logic [3:0]       next_pass;
  logic [8:0]       next_base;
  logic             more_passes;
  logic [VLEN-1:0]  vb_scalar;
  logic [VLENB-1:0] be;
  logic [VLEN-1:0]  vmask;
  logic             in_exec;

  // Request decode and legality of the latched instruction.
  assign req_vlmax   = vlmax(req_vsew_i, req_vlmul_i);
  assign vm          = opcode_q[25];
  assign funct3      = opcode_q[14:12];
  assign scalar_form = (funct3 == 3'b011) || (funct3 == 3'b100) ||
                       (funct3 == 3'b101) || (funct3 == 3'b110);
  assign lmul_cnt    = 5'd1 << vlmul_q;
  assign lmul_low    = lmul_cnt - 5'd1;
  assign misaligned  = |((vd_q | vs1_q | vs2_q) & lmul_low);
`ifdef BIRISCV_VSEQ_MASK_EN
  assign mask_illegal = !vm && (vd_q == 5'd0);
`else
  assign mask_illegal = !vm;
`endif
  assign illegal     = (vsew_q == SEW_RSVD) || misaligned || mask_illegal;

  // Another pass is needed while the group and the (clamped) vl both extend further.
  assign next_pass   = {1'b0, pass_q} + 4'd1;
  assign next_base   = 9'({next_pass, {BYTE_W{1'b0}}}) >> vsew_q;
  assign more_passes = (5'(next_pass) < lmul_cnt) && (next_base < 9'(vl_q));

  // Replicate the scalar operand into every SEW-wide element.
  always_comb begin
    vb_scalar = '0;
    unique case (vsew_q)
      SEW_8:   vb_scalar = {(VLEN / 8){scalar_q[7:0]}};
      SEW_16:  vb_scalar = {(VLEN / 16){scalar_q[15:0]}};
      default: vb_scalar = {(VLEN / 32){scalar_q[31:0]}};
    endcase
  end

  biriscv_v_elem_enable u_elem_enable (
    .pass_idx (pass_q),
    .vl       (vl_q),
    .vsew     (vsew_q),
    .vm       (vm),
    .v0       (vrf_rd_data_m_i),
    .byte_en  (be),
    .vmask    (vmask)
  );

  // ALU operands are only driven while the read data is valid.
  assign in_exec     = (state_q == ST_EXEC);
  assign alu_opcode_o = opcode_q;
  assign alu_va_o    = in_exec ? vrf_rd_data_a_i : '0;
  assign alu_vb_o    = in_exec ? (scalar_form ? vb_scalar : vrf_rd_data_b_i) : '0;
  assign alu_vmask_o = in_exec ? vmask : '0;

  assign req_ready_o     = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign vrf_rd_addr_a_o = rd_addr_a_q;
  assign vrf_rd_addr_b_o = rd_addr_b_q;
  assign vrf_wr_addr_o   = wr_addr_q;
  assign vrf_wr_data_o   = wr_data_q;
  assign vrf_wr_be_o     = wr_be_q;

  // Strobes fire only on the cycle the FSM actually leaves the state.
  assign vrf_wr_en_o = (state_q == ST_WRITE) && !hold_i;
  assign illegal_o   = (state_q == ST_CHECK) && illegal && !hold_i;
  assign done_o      = !hold_i &&
                       (((state_q == ST_CHECK) && !illegal && (vl_q == 8'd0)) ||
                        ((state_q == ST_WRITE) && !more_passes));

  // Sequencer FSM; hold_i freezes every state past IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pass_q      <= '0;
      opcode_q    <= '0;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      scalar_q    <= '0;
      vl_q        <= '0;
      vsew_q      <= '0;
      vlmul_q     <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            opcode_q <= req_opcode_i;
            vd_q     <= req_vd_i;
            vs1_q    <= req_vs1_i;
            vs2_q    <= req_vs2_i;
            scalar_q <= req_rs1_operand_i;
            vl_q     <= (req_vl_i > req_vlmax) ? req_vlmax : req_vl_i;
            vsew_q   <= req_vsew_i;
            vlmul_q  <= req_vlmul_i;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!hold_i) begin
            if (illegal || (vl_q == 8'd0)) begin
              state_q <= ST_IDLE;
            end else begin
              pass_q      <= '0;
              rd_addr_a_q <= vs2_q;
              rd_addr_b_q <= vs1_q;
              state_q     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (!hold_i) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!hold_i) begin
            wr_data_q <= alu_result_i;
            wr_be_q   <= be;
            wr_addr_q <= vd_q + 5'(pass_q);
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!hold_i) begin
            if (more_passes) begin
              pass_q      <= next_pass[2:0];
              rd_addr_a_q <= vs2_q + 5'(next_pass);
              rd_addr_b_q <= vs1_q + 5'(next_pass);
              state_q     <= ST_READ;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biriscv_v_alu_seq.sv
// Scoreboard bench for biriscv_v_alu_seq: VRF and ALU models around the DUT,
// expected writes/pulses queued per instruction and checked by a monitor.
`timescale 1ns/1ps
module tb_biriscv_v_alu_seq;
  import biriscv_v_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [31:0]       req_opcode_i = '0;
  logic [4:0]        req_vd_i = '0, req_vs1_i = '0, req_vs2_i = '0;
  logic [ELEN-1:0]   req_rs1_operand_i = '0;
  logic [7:0]        req_vl_i = '0;
  logic [1:0]        req_vsew_i = '0, req_vlmul_i = '0;
  logic              hold_i = 1'b0;
  logic [4:0]        vrf_rd_addr_a_o, vrf_rd_addr_b_o;
  logic [VLEN-1:0]   rd_a = '0, rd_b = '0;
  logic [VLEN-1:0]   vrf_rd_data_m_i;
  logic [31:0]       alu_opcode_o;
  logic [VLEN-1:0]   alu_va_o, alu_vb_o, alu_vmask_o, alu_result_i;
  logic              vrf_wr_en_o;
  logic [4:0]        vrf_wr_addr_o;
  logic [VLEN-1:0]   vrf_wr_data_o;
  logic [VLENB-1:0]  vrf_wr_be_o;
  logic              busy_o, done_o, illegal_o;

  localparam int K_WR = 0, K_DONE = 1, K_ILL = 2;

  typedef struct {
    int               kind;
    logic [4:0]       addr;
    logic [VLEN-1:0]  data;
    logic [VLENB-1:0] be;
    int               lat;
  } exp_t;

  exp_t  exp_q[$];
  int    n_pass = 0, n_total = 0;
  int    cyc = 0, acc_cyc = 0;
  string tname = "reset";
  logic [VLEN-1:0] vrf [32];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // VRF model: synchronous read ports, v0 hard-wired; ALU model mixes in the mask.
  always @(posedge clk_i) begin
    rd_a <= vrf[vrf_rd_addr_a_o];
    rd_b <= vrf[vrf_rd_addr_b_o];
  end
  assign vrf_rd_data_m_i = vrf[0];
  assign alu_result_i    = alu_va_o ^ alu_vb_o ^ alu_vmask_o;

  biriscv_v_alu_seq dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .req_valid_i (req_valid_i), .req_ready_o (req_ready_o),
    .req_opcode_i (req_opcode_i), .req_vd_i (req_vd_i),
    .req_vs1_i (req_vs1_i), .req_vs2_i (req_vs2_i),
    .req_rs1_operand_i (req_rs1_operand_i), .req_vl_i (req_vl_i),
    .req_vsew_i (req_vsew_i), .req_vlmul_i (req_vlmul_i), .hold_i (hold_i),
    .vrf_rd_addr_a_o (vrf_rd_addr_a_o), .vrf_rd_addr_b_o (vrf_rd_addr_b_o),
    .vrf_rd_data_a_i (rd_a), .vrf_rd_data_b_i (rd_b), .vrf_rd_data_m_i (vrf_rd_data_m_i),
    .alu_opcode_o (alu_opcode_o), .alu_va_o (alu_va_o), .alu_vb_o (alu_vb_o),
    .alu_vmask_o (alu_vmask_o), .alu_result_i (alu_result_i),
    .vrf_wr_en_o (vrf_wr_en_o), .vrf_wr_addr_o (vrf_wr_addr_o),
    .vrf_wr_data_o (vrf_wr_data_o), .vrf_wr_be_o (vrf_wr_be_o),
    .busy_o (busy_o), .done_o (done_o), .illegal_o (illegal_o)
  );

  function automatic string kname(input int k);
    return (k == K_WR) ? "write" : (k == K_DONE) ? "done" : "illegal";
  endfunction

  // Expected ALU mask: active bit at each element LSB (all element LSBs without masking support).
  function automatic logic [VLEN-1:0] vmask_of(input int sew, input logic [VLENB-1:0] be);
    logic [VLEN-1:0]  m;
    logic [VLENB-1:0] act;
    act = be;
`ifndef BIRISCV_VSEQ_MASK_EN
    act = '1;
`endif
    m = '0;
    for (int b = 0; b < int'(VLENB); b++)
      if (act[b] && (b % (1 << sew)) == 0) m[b * 8] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] mk_op(input logic vm, input logic [2:0] f3,
                                        input logic [4:0] vd, input logic [4:0] vs1,
                                        input logic [4:0] vs2);
    return {6'b000000, vm, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  task automatic push(input int kind, input logic [4:0] addr, input logic [VLEN-1:0] data,
                      input logic [VLENB-1:0] be, input int lat);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.be = be; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    exp_t e;
    int   lat;
    lat = cyc - acc_cyc;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected %s at latency %0d (addr=%0d be=%h), none expected",
               tname, kname(kind), lat, vrf_wr_addr_o, vrf_wr_be_o);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.lat != lat ||
          (kind == K_WR && (vrf_wr_addr_o !== e.addr || vrf_wr_data_o !== e.data ||
                            vrf_wr_be_o !== e.be)))
        $display("FAIL %s: got %s lat=%0d addr=%0d be=%h data=%h, expected %s lat=%0d addr=%0d be=%h data=%h",
                 tname, kname(kind), lat, vrf_wr_addr_o, vrf_wr_be_o, vrf_wr_data_o,
                 kname(e.kind), e.lat, e.addr, e.be, e.data);
      else
        n_pass++;
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (vrf_wr_en_o) take(K_WR);
      if (done_o)      take(K_DONE);
      if (illegal_o)   take(K_ILL);
    end
  end

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic issue(input string nm, input logic vm, input logic [2:0] f3,
                       input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [31:0] sc, input logic [7:0] vl,
                       input logic [1:0] sew, input logic [1:0] lmul);
    @(negedge clk_i);
    tname             = nm;
    req_opcode_i      = mk_op(vm, f3, vd, vs1, vs2);
    req_vd_i          = vd;
    req_vs1_i         = vs1;
    req_vs2_i         = vs2;
    req_rs1_operand_i = sc;
    req_vl_i          = vl;
    req_vsew_i        = sew;
    req_vlmul_i       = lmul;
    req_valid_i       = 1'b1;
    acc_cyc           = cyc;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  // Wait (bounded) for the instruction to retire and all expectations to be consumed.
  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 200) begin
      @(negedge clk_i);
      #1 n++;
    end
    n_total++;
    if (exp_q.size() == 0 && !busy_o) n_pass++;
    else begin
      $display("FAIL %s_drain: %0d events still pending, busy=%0b", nm, exp_q.size(), busy_o);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      vrf[i] = {32'(i) * 32'h9E37_79B9, (32'(i) * 32'h0101_0101) ^ 32'hFFFF_0000,
                (32'(i) << 8) ^ 32'hDEAD_BEEF, 32'h1234_5678 + 32'(i)};
    vrf[0] = {96'h0, 32'h0000_00F5};

    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_ready",   VLEN'(req_ready_o), VLEN'(1));
    chk("rst_busy",    VLEN'(busy_o),      '0);
    chk("rst_pulses",  VLEN'({vrf_wr_en_o, done_o, illegal_o}), '0);
    chk("rst_wr_be",   VLEN'(vrf_wr_be_o), '0);
    chk("rst_rd_addr", VLEN'({vrf_rd_addr_a_o, vrf_rd_addr_b_o, vrf_wr_addr_o}), '0);
    chk("rst_vmask",   alu_vmask_o, '0);

    // vadd.vv SEW=32 LMUL=1 vl=4: single full pass
    push(K_WR, 5'd2, vrf[4] ^ vrf[5] ^ vmask_of(2, 16'hFFFF), 16'hFFFF, 4);
    push(K_DONE, '0, '0, '0, 4);
    issue("vv_sew32", 1'b1, 3'b000, 5'd2, 5'd5, 5'd4, 32'h0, 8'd4, 2'd2, 2'd0);
    drain("vv_sew32");

    // SEW=8 LMUL=2 vl=20: full pass then 4-byte tail
    push(K_WR, 5'd6, vrf[8] ^ vrf[10] ^ vmask_of(0, 16'hFFFF), 16'hFFFF, 4);
    push(K_WR, 5'd7, vrf[9] ^ vrf[11] ^ vmask_of(0, 16'h000F), 16'h000F, 7);
    push(K_DONE, '0, '0, '0, 7);
    issue("vv_sew8_lmul2", 1'b1, 3'b000, 5'd6, 5'd10, 5'd8, 32'h0, 8'd20, 2'd0, 2'd1);
    drain("vv_sew8_lmul2");

    // SEW=16 LMUL=4 vl=10: early exit after two passes
    push(K_WR, 5'd12, vrf[16] ^ vrf[20] ^ vmask_of(1, 16'hFFFF), 16'hFFFF, 4);
    push(K_WR, 5'd13, vrf[17] ^ vrf[21] ^ vmask_of(1, 16'h000F), 16'h000F, 7);
    push(K_DONE, '0, '0, '0, 7);
    issue("early_exit", 1'b1, 3'b000, 5'd12, 5'd20, 5'd16, 32'h0, 8'd10, 2'd1, 2'd2);
    drain("early_exit");

    // vm=0 SEW=32 vl=4 with v0 = ...0101
`ifdef BIRISCV_VSEQ_MASK_EN
    push(K_WR, 5'd1, vrf[4] ^ vrf[8] ^ vmask_of(2, 16'h0F0F), 16'h0F0F, 4);
    push(K_DONE, '0, '0, '0, 4);
`else
    push(K_ILL, '0, '0, '0, 1);
`endif
    issue("masked", 1'b0, 3'b000, 5'd1, 5'd8, 5'd4, 32'h0, 8'd4, 2'd2, 2'd0);
    drain("masked");

    // LMUL=2 with odd vd is rejected; ready again the next cycle
    push(K_ILL, '0, '0, '0, 1);
    issue("misalign_vd", 1'b1, 3'b000, 5'd3, 5'd4, 5'd6, 32'h0, 8'd8, 2'd2, 2'd1);
    @(posedge clk_i);
    #1 chk("ready_after_illegal", VLEN'(req_ready_o), VLEN'(1));
    drain("misalign_vd");

    // Reserved SEW and misaligned vs2 are both illegal
    push(K_ILL, '0, '0, '0, 1);
    issue("sew_rsvd", 1'b1, 3'b000, 5'd4, 5'd4, 5'd4, 32'h0, 8'd4, 2'd3, 2'd0);
    drain("sew_rsvd");
    push(K_ILL, '0, '0, '0, 1);
    issue("misalign_vs2", 1'b1, 3'b000, 5'd4, 5'd8, 5'd6, 32'h0, 8'd4, 2'd2, 2'd2);
    drain("misalign_vs2");

    // vl=0 completes in the check cycle without writing
    push(K_DONE, '0, '0, '0, 1);
    issue("vl_zero", 1'b1, 3'b000, 5'd2, 5'd3, 5'd4, 32'h0, 8'd0, 2'd0, 2'd0);
    drain("vl_zero");

    // .vx form, SEW=8, vl=5: scalar byte broadcast, 5-byte body
    push(K_WR, 5'd3, vrf[5] ^ {16{8'hA5}} ^ vmask_of(0, 16'h001F), 16'h001F, 4);
    push(K_DONE, '0, '0, '0, 4);
    issue("vx_sew8", 1'b1, 3'b100, 5'd3, 5'd0, 5'd5, 32'h1234_56A5, 8'd5, 2'd0, 2'd0);
    drain("vx_sew8");

    // vl above VLMAX clamps to one full pass
    push(K_WR, 5'd9, vrf[10] ^ vrf[11] ^ vmask_of(2, 16'hFFFF), 16'hFFFF, 4);
    push(K_DONE, '0, '0, '0, 4);
    issue("vl_clamp", 1'b1, 3'b000, 5'd9, 5'd11, 5'd10, 32'h0, 8'd100, 2'd2, 2'd0);
    drain("vl_clamp");

    // hold_i for 3 cycles in WRITE: one write, done delayed by 3
    push(K_WR, 5'd2, vrf[4] ^ vrf[5] ^ vmask_of(2, 16'hFFFF), 16'hFFFF, 7);
    push(K_DONE, '0, '0, '0, 7);
    issue("hold_write", 1'b1, 3'b000, 5'd2, 5'd5, 5'd4, 32'h0, 8'd4, 2'd2, 2'd0);
    repeat (3) @(posedge clk_i);
    #1 hold_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 chk("busy_during_hold", VLEN'(busy_o), VLEN'(1));
    @(posedge clk_i);
    #1 hold_i = 1'b0;
    drain("hold_write");

    // Asynchronous reset mid-instruction: pass 0 write stays, FSM back to IDLE at once
    push(K_WR, 5'd8, vrf[16] ^ vrf[24] ^ vmask_of(0, 16'hFFFF), 16'hFFFF, 4);
    issue("async_reset", 1'b1, 3'b000, 5'd8, 5'd24, 5'd16, 32'h0, 8'd128, 2'd0, 2'd3);
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("reset_busy",  VLEN'(busy_o),      '0);
    chk("reset_ready", VLEN'(req_ready_o), VLEN'(1));
    chk("reset_wr_en", VLEN'(vrf_wr_en_o), '0);
    #1 rst_i = 1'b0;
    drain("async_reset");

    // Instruction after reset runs normally
    push(K_WR, 5'd2, vrf[4] ^ vrf[5] ^ vmask_of(2, 16'hFFFF), 16'hFFFF, 4);
    push(K_DONE, '0, '0, '0, 4);
    issue("after_reset", 1'b1, 3'b000, 5'd2, 5'd5, 5'd4, 32'h0, 8'd4, 2'd2, 2'd0);
    drain("after_reset");

    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
